control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
// - Multi-cycle sequencer of the copperv core. It runs fetch, decode, execute, store and retire for one instruction at a time.
// - Inputs: inst_type/funct from idecoder, the branch compare result from the ALU, and the valid/ready handshakes of the instruction and data buses.
// - Outputs: enables and mux selects for the PC, instruction register (IR), register file and ALU.
// PARAMETERS
// - TIMEOUT_WIDTH  8  width of the bus-wait counter; 2**TIMEOUT_WIDTH-1 cycles without a handshake raises bus_error
// PORTS
// - clk            in   1                 core clock
// - rst_n          in   1                 asynchronous active-low reset
// - inst_type      in   INST_TYPE_WIDTH   decoded type (0 = none/illegal)
// - funct          in   FUNCT_WIDTH       decoded function (0 = none)
// - branch_taken   in   1                 ALU compare result for the current funct
// - ir_addr_valid  out  1                 instruction read request, address = pc
// - ir_addr_ready  in   1
// - ir_data_valid  in   1                 instruction word returned
// - ir_data_ready  out  1
// - dw_valid       out  1                 store request (addr/data/strobe come from the datapath)
// - dw_ready       in   1
// - dw_resp_valid  in   1                 store completion
// - dw_resp_ready  out  1
// - inst_load      out  1                 latch the returned word into IR
// - pc_en          out  1                 update pc at this edge
// - pc_sel         out  2                 0: pc+4; 1: pc+imm
// - alu_src_sel    out  1                 0: rs2; 1: imm
// - alu_op         out  FUNCT_WIDTH       registered funct, valid in EXEC/STORE
// - rd_en          out  1                 register-file write strobe
// - rd_din_sel     out  2                 0: ALU; 1: imm (LUI); 2: old pc+4 (JAL)
// - illegal_inst   out  1                 sticky flag
// - bus_error      out  1                 sticky flag
// BEHAVIOUR
// - States: IDLE, FETCH, FETCH_WAIT, DECODE, EXEC, STORE, STORE_WAIT, HALT.
// - Outputs are combinational from state plus registered type_q/funct_q. Flags are registered.
// - Reset: state=IDLE, type_q=funct_q=0, counter=0, both flags 0. Every output is 0 while rst_n=0.
//   - Asserting rst_n mid-operation drops requests at once, without a handshake; the bus must tolerate this.
// - IDLE: 1 cycle, then FETCH.
// - FETCH: ir_addr_valid=1, held until ir_addr_ready, then FETCH_WAIT. Ready in the first valid cycle counts as a handshake.
// - FETCH_WAIT: ir_data_ready=1. On ir_data_valid: inst_load=1 in that cycle, then DECODE.
//   - Data arriving during FETCH is not consumed; the bus holds it.
// - DECODE: 1 cycle for idecoder to settle on the IR. type_q<=inst_type, funct_q<=funct.
//   - Go to HALT with illegal_inst<=1 if inst_type==0, or if funct==0 for INT_IMM/INT_REG/BRANCH/STORE. Otherwise go to EXEC.
// - EXEC: alu_op=funct_q; alu_src_sel=1 for INT_IMM/STORE, else 0. Then FETCH, except STORE, which goes to STORE:
//   - IMM (LUI): rd_en=1, rd_din_sel=1, pc_en=1, pc_sel=0.
//   - INT_IMM/INT_REG: rd_en=1, rd_din_sel=0, pc_en=1, pc_sel=0.
//   - JAL: rd_en=1, rd_din_sel=2, pc_en=1, pc_sel=1.
//   - BRANCH: rd_en=0, pc_en=1, pc_sel=branch_taken.
//   - STORE: no enables.
// - STORE: dw_valid=1 with alu_op/alu_src_sel still driven, held until dw_ready, then STORE_WAIT.
// - STORE_WAIT: dw_resp_ready=1. On dw_resp_valid: pc_en=1, pc_sel=0, then FETCH.
// - rd_en and pc_en are asserted for exactly 1 cycle per instruction. rd_en never outside EXEC.
// - Minimum CPI with a zero-wait bus: 4 (non-store), 6 (store).
// - Timeout counter:
//   - Cleared on entry to FETCH, FETCH_WAIT, STORE and STORE_WAIT.
//   - Increments every cycle in those states without the awaited handshake; saturates.
//   - Reaching all-ones sets bus_error<=1 and goes to HALT, dropping the pending request.
// - HALT: all request/enable outputs 0. Exit only by reset.
// STRUCTURE
// - copperv_h.v gains: CTRL_STATE_* encodings and width, PC_SEL_*, RD_DIN_SEL_*, ALU_SRC_*, and FUNCT_NONE (0, reserved).
// - One sub-module, bus_wait_timer: clear/count/expired, TIMEOUT_WIDTH wide, asynchronous active-low reset.
// TESTING
// - Zero-wait bus, ADDI x1,x0,5 (0x00500093):
//   - ir_addr_valid 1 cycle after reset release.
//   - EXEC in cycle 4: rd_en=1, rd_din_sel=0, alu_src_sel=1, pc_en=1, pc_sel=0.
//   - Next FETCH in cycle 5.
// - JAL x1,8 (0x008000EF) -> EXEC rd_din_sel=2, pc_sel=1.
//   BEQ x0,x0,8 (0x00000463), branch_taken=0 -> pc_sel=0, rd_en=0; branch_taken=1 -> pc_sel=1.
// - SW x1,4(x2) (0x00112223), dw_ready delayed 3 cycles, dw_resp_valid 2 cycles later:
//   - dw_valid stable for 4 cycles.
//   - pc_en only in the dw_resp_valid cycle.
//   - rd_en never asserted.
// - 0x00000000, and SLLI 0x00101093 (funct 0) -> illegal_inst=1 after DECODE, HALT, no further ir_addr_valid.
// - TIMEOUT_WIDTH=4, ir_addr_ready held 0 -> bus_error=1 after 15 waiting cycles, ir_addr_valid drops, HALT.
// - rst_n asserted in STORE_WAIT -> all outputs 0 at once, no pc_en; fetch restarts 1 cycle after release, flags 0.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Purpose: shared encodings for the copperv control unit: instruction types,
//          function codes, sequencer states and the datapath mux selects.
// Contents: widths, INST_TYPE_*, FUNCT_*, ctrl_state_e, PC_SEL_*,
//           RD_DIN_SEL_*, ALU_SRC_*, and decode helper functions.
package control_unit_pkg;

  localparam int INST_TYPE_WIDTH = 3;
  localparam int FUNCT_WIDTH     = 5;

  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_NONE    = 3'd0;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_IMM     = 3'd1;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_INT_IMM = 3'd2;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_INT_REG = 3'd3;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_BRANCH  = 3'd4;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_STORE   = 3'd5;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_JAL     = 3'd6;

  // FUNCT_NONE is reserved: it never names a real ALU operation.
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_NONE     = 5'd0;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_ADD      = 5'd1;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLL      = 5'd3;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_EQ       = 5'd11;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_WORD = 5'd19;

  localparam int CTRL_STATE_WIDTH = 3;
  typedef enum logic [CTRL_STATE_WIDTH-1:0] {
    CTRL_STATE_IDLE       = 3'd0,
    CTRL_STATE_FETCH      = 3'd1,
    CTRL_STATE_FETCH_WAIT = 3'd2,
    CTRL_STATE_DECODE     = 3'd3,
    CTRL_STATE_EXEC       = 3'd4,
    CTRL_STATE_STORE      = 3'd5,
    CTRL_STATE_STORE_WAIT = 3'd6,
    CTRL_STATE_HALT       = 3'd7
  } ctrl_state_e;

  localparam logic [1:0] PC_SEL_PC_PLUS_4   = 2'd0;
  localparam logic [1:0] PC_SEL_PC_PLUS_IMM = 2'd1;

  localparam logic [1:0] RD_DIN_SEL_ALU       = 2'd0;
  localparam logic [1:0] RD_DIN_SEL_IMM       = 2'd1;
  localparam logic [1:0] RD_DIN_SEL_PC_PLUS_4 = 2'd2;

  localparam logic ALU_SRC_RS2 = 1'b0;
  localparam logic ALU_SRC_IMM = 1'b1;

  // True for every type the sequencer knows how to execute.
  function automatic logic inst_type_known(input logic [INST_TYPE_WIDTH-1:0] t);
    case (t)
      INST_TYPE_IMM, INST_TYPE_INT_IMM, INST_TYPE_INT_REG,
      INST_TYPE_BRANCH, INST_TYPE_STORE, INST_TYPE_JAL: inst_type_known = 1'b1;
      default:                                          inst_type_known = 1'b0;
    endcase
  endfunction

  // Types whose execution depends on a real ALU function.
  function automatic logic funct_required(input logic [INST_TYPE_WIDTH-1:0] t);
    case (t)
      INST_TYPE_INT_IMM, INST_TYPE_INT_REG,
      INST_TYPE_BRANCH, INST_TYPE_STORE: funct_required = 1'b1;
      default:                           funct_required = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_bus_wait_timer.sv
// Purpose: saturating wait counter guarding bus handshakes.
// Ports: clk, rst_n (async active-low), clear_i (restart from 0, wins over
//        count), count_i (one more cycle without handshake), expired_o
//        (counter is all-ones).
module bus_wait_timer #(
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == {TIMEOUT_WIDTH{1'b1}});

  // Next count: clear has priority, saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {TIMEOUT_WIDTH{1'b0}};
    end else if (count_i && !expired_o) begin
      cnt_d = cnt_q + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {TIMEOUT_WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Purpose: multi-cycle sequencer of the copperv core (fetch, decode, execute,
//          store, retire), one instruction at a time.
// Ports: clk/rst_n; inst_type/funct from idecoder; branch_taken from ALU;
//        instruction bus (ir_addr_*, ir_data_*) and store bus (dw_*,
//        dw_resp_*) handshakes; datapath controls inst_load, pc_en, pc_sel,
//        alu_src_sel, alu_op, rd_en, rd_din_sel; sticky illegal_inst and
//        bus_error flags.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [INST_TYPE_WIDTH-1:0] inst_type,
  input  logic [FUNCT_WIDTH-1:0]     funct,
  input  logic                       branch_taken,
  output logic                       ir_addr_valid,
  input  logic                       ir_addr_ready,
  input  logic                       ir_data_valid,
  output logic                       ir_data_ready,
  output logic                       dw_valid,
  input  logic                       dw_ready,
  input  logic                       dw_resp_valid,
  output logic                       dw_resp_ready,
  output logic                       inst_load,
  output logic                       pc_en,
  output logic [1:0]                 pc_sel,
  output logic                       alu_src_sel,
  output logic [FUNCT_WIDTH-1:0]     alu_op,
  output logic                       rd_en,
  output logic [1:0]                 rd_din_sel,
  output logic                       illegal_inst,
  output logic                       bus_error
);

  ctrl_state_e                state_q, state_d;
  logic [INST_TYPE_WIDTH-1:0] type_q, type_d;
  logic [FUNCT_WIDTH-1:0]     funct_q, funct_d;
  logic                       illegal_q, illegal_d;
  logic                       bus_err_q, bus_err_d;
  logic                       tmr_clear_s, tmr_count_s, tmr_expired_s;

  // Any state change restarts the wait counter, so each wait state starts at 0.
  assign tmr_clear_s  = (state_d != state_q);
  assign illegal_inst = illegal_q;
  assign bus_error    = bus_err_q;

  bus_wait_timer #(.TIMEOUT_WIDTH(TIMEOUT_WIDTH)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (tmr_clear_s),
    .count_i   (tmr_count_s),
    .expired_o (tmr_expired_s)
  );

  // Next-state, captured decode fields, flags and all datapath controls.
  always_comb begin
    state_d       = state_q;
    type_d        = type_q;
    funct_d       = funct_q;
    illegal_d     = illegal_q;
    bus_err_d     = bus_err_q;
    tmr_count_s   = 1'b0;
    ir_addr_valid = 1'b0;
    ir_data_ready = 1'b0;
    dw_valid      = 1'b0;
    dw_resp_ready = 1'b0;
    inst_load     = 1'b0;
    pc_en         = 1'b0;
    pc_sel        = PC_SEL_PC_PLUS_4;
    alu_src_sel   = ALU_SRC_RS2;
    alu_op        = FUNCT_NONE;
    rd_en         = 1'b0;
    rd_din_sel    = RD_DIN_SEL_ALU;
    case (state_q)
      CTRL_STATE_IDLE: begin
        state_d = CTRL_STATE_FETCH;
      end
      CTRL_STATE_FETCH: begin
        // An expired wait withdraws the request in the same cycle.
        if (tmr_expired_s) begin
          bus_err_d = 1'b1;
          state_d   = CTRL_STATE_HALT;
        end else begin
          ir_addr_valid = 1'b1;
          tmr_count_s   = !ir_addr_ready;
          if (ir_addr_ready) begin
            state_d = CTRL_STATE_FETCH_WAIT;
          end else begin
            state_d = CTRL_STATE_FETCH;
          end
        end
      end
      CTRL_STATE_FETCH_WAIT: begin
        if (tmr_expired_s) begin
          bus_err_d = 1'b1;
          state_d   = CTRL_STATE_HALT;
        end else begin
          ir_data_ready = 1'b1;
          tmr_count_s   = !ir_data_valid;
          if (ir_data_valid) begin
            inst_load = 1'b1;
            state_d   = CTRL_STATE_DECODE;
          end else begin
            state_d = CTRL_STATE_FETCH_WAIT;
          end
        end
      end
      CTRL_STATE_DECODE: begin
        type_d  = inst_type;
        funct_d = funct;
        if (!inst_type_known(inst_type) ||
            (funct_required(inst_type) && (funct == FUNCT_NONE))) begin
          illegal_d = 1'b1;
          state_d   = CTRL_STATE_HALT;
        end else begin
          state_d = CTRL_STATE_EXEC;
        end
      end
      CTRL_STATE_EXEC: begin
        alu_op = funct_q;
        if ((type_q == INST_TYPE_INT_IMM) || (type_q == INST_TYPE_STORE)) begin
          alu_src_sel = ALU_SRC_IMM;
        end else begin
          alu_src_sel = ALU_SRC_RS2;
        end
        state_d = CTRL_STATE_FETCH;
        case (type_q)
          INST_TYPE_IMM: begin
            rd_en      = 1'b1;
            rd_din_sel = RD_DIN_SEL_IMM;
            pc_en      = 1'b1;
          end
          INST_TYPE_INT_IMM, INST_TYPE_INT_REG: begin
            rd_en = 1'b1;
            pc_en = 1'b1;
          end
          INST_TYPE_JAL: begin
            rd_en      = 1'b1;
            rd_din_sel = RD_DIN_SEL_PC_PLUS_4;
            pc_en      = 1'b1;
            pc_sel     = PC_SEL_PC_PLUS_IMM;
          end
          INST_TYPE_BRANCH: begin
            pc_en  = 1'b1;
            pc_sel = {1'b0, branch_taken};
          end
          INST_TYPE_STORE: begin
            state_d = CTRL_STATE_STORE;
          end
          default: begin
            // Unreachable: DECODE only lets known types through.
            illegal_d = 1'b1;
            state_d   = CTRL_STATE_HALT;
          end
        endcase
      end
      CTRL_STATE_STORE: begin
        alu_op      = funct_q;
        alu_src_sel = ALU_SRC_IMM;
        if (tmr_expired_s) begin
          bus_err_d = 1'b1;
          state_d   = CTRL_STATE_HALT;
        end else begin
          dw_valid    = 1'b1;
          tmr_count_s = !dw_ready;
          if (dw_ready) begin
            state_d = CTRL_STATE_STORE_WAIT;
          end else begin
            state_d = CTRL_STATE_STORE;
          end
        end
      end
      CTRL_STATE_STORE_WAIT: begin
        if (tmr_expired_s) begin
          bus_err_d = 1'b1;
          state_d   = CTRL_STATE_HALT;
        end else begin
          dw_resp_ready = 1'b1;
          tmr_count_s   = !dw_resp_valid;
          if (dw_resp_valid) begin
            pc_en   = 1'b1;
            state_d = CTRL_STATE_FETCH;
          end else begin
            state_d = CTRL_STATE_STORE_WAIT;
          end
        end
      end
      CTRL_STATE_HALT: begin
        state_d = CTRL_STATE_HALT;
      end
      default: begin
        state_d = CTRL_STATE_HALT;
      end
    endcase
  end

  // State, decode capture and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CTRL_STATE_IDLE;
      type_q    <= INST_TYPE_NONE;
      funct_q   <= FUNCT_NONE;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      funct_q   <= funct_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes the expected retire
// controls, a monitor pops and compares whenever pc_en or rd_en is raised.
module tb_control_unit;
  import control_unit_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b1;
  logic [INST_TYPE_WIDTH-1:0] inst_type = INST_TYPE_NONE;
  logic [FUNCT_WIDTH-1:0]     funct = FUNCT_NONE;
  logic                       branch_taken = 1'b0;
  logic                       ir_addr_ready = 1'b0;
  logic                       ir_data_valid = 1'b0;
  logic                       dw_ready = 1'b0;
  logic                       dw_resp_valid = 1'b0;
  logic                       ir_addr_valid, ir_data_ready, dw_valid, dw_resp_ready;
  logic                       inst_load, pc_en, alu_src_sel, rd_en;
  logic                       illegal_inst, bus_error;
  logic [1:0]                 pc_sel, rd_din_sel;
  logic [FUNCT_WIDTH-1:0]     alu_op;
  logic [18:0]                outs;

  control_unit #(.TIMEOUT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .inst_type(inst_type), .funct(funct),
    .branch_taken(branch_taken), .ir_addr_valid(ir_addr_valid),
    .ir_addr_ready(ir_addr_ready), .ir_data_valid(ir_data_valid),
    .ir_data_ready(ir_data_ready), .dw_valid(dw_valid), .dw_ready(dw_ready),
    .dw_resp_valid(dw_resp_valid), .dw_resp_ready(dw_resp_ready),
    .inst_load(inst_load), .pc_en(pc_en), .pc_sel(pc_sel),
    .alu_src_sel(alu_src_sel), .alu_op(alu_op), .rd_en(rd_en),
    .rd_din_sel(rd_din_sel), .illegal_inst(illegal_inst), .bus_error(bus_error)
  );

  assign outs = {ir_addr_valid, ir_data_ready, dw_valid, dw_resp_ready, inst_load,
                 pc_en, pc_sel, alu_src_sel, alu_op, rd_en, rd_din_sel,
                 illegal_inst, bus_error};

  always #5 clk = ~clk;

  typedef struct packed {
    logic                   rd_en;
    logic [1:0]             rd_din_sel;
    logic [1:0]             pc_sel;
    logic                   alu_src_sel;
    logic [FUNCT_WIDTH-1:0] alu_op;
    logic                   store_done;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int   dw_delay = 0, resp_delay = 0;
  int   dw_cnt = 0, resp_cnt = 0;
  bit   addr_stall = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic rd, input logic [1:0] din, input logic [1:0] ps,
                              input logic src, input logic [FUNCT_WIDTH-1:0] op,
                              input logic sd);
    exp_t e;
    e.rd_en = rd; e.rd_din_sel = din; e.pc_sel = ps;
    e.alu_src_sel = src; e.alu_op = op; e.store_done = sd;
    return e;
  endfunction

  // Bus model: reacts shortly after each rising edge to the current requests.
  always @(posedge clk) begin
    #1;
    ir_addr_ready = ir_addr_valid && !addr_stall;
    ir_data_valid = ir_data_ready;
    if (dw_valid) begin
      dw_ready = (dw_cnt >= dw_delay);
      dw_cnt++;
    end else begin
      dw_ready = 1'b0;
      dw_cnt = 0;
    end
    if (dw_resp_ready) begin
      dw_resp_valid = (resp_cnt >= resp_delay);
      resp_cnt++;
    end else begin
      dw_resp_valid = 1'b0;
      resp_cnt = 0;
    end
  end

  // Monitor: every pc_en/rd_en pulse must match the oldest expected retire.
  always @(negedge clk) begin
    if (rst_n && (pc_en || rd_en)) begin
      if (sb_q.size() == 0) begin
        check("spurious_enable", 32'({pc_en, rd_en}), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("retire_pc_en", 32'(pc_en), 32'd1);
        check("retire_rd_en", 32'(rd_en), 32'(e.rd_en));
        check("retire_pc_sel", 32'(pc_sel), 32'(e.pc_sel));
        if (e.rd_en) check("retire_rd_din_sel", 32'(rd_din_sel), 32'(e.rd_din_sel));
        if (e.store_done) begin
          check("retire_store_resp", 32'(dw_resp_valid & dw_resp_ready), 32'd1);
        end else begin
          check("retire_alu_src_sel", 32'(alu_src_sel), 32'(e.alu_src_sel));
          check("retire_alu_op", 32'(alu_op), 32'(e.alu_op));
        end
      end
    end
  end

  // Wait for the instruction word to be loaded, then present its decode.
  task automatic issue(input logic [INST_TYPE_WIDTH-1:0] t, input logic [FUNCT_WIDTH-1:0] f,
                       input logic bt, input bit push, input exp_t e);
    bit seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (inst_load) begin
        seen = 1'b1;
        break;
      end
    end
    check("inst_load_seen", 32'(seen), 32'd1);
    inst_type = t;
    funct = f;
    branch_taken = bt;
    if (push) sb_q.push_back(e);
  endtask

  task automatic check_halted(input string nm);
    int req = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ir_addr_valid || pc_en || rd_en) req++;
    end
    check(nm, 32'(req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int dv, pcc, pcbad, rdc, stbad, cnt;
    exp_t none;
    none = mk(1'b0, 2'd0, 2'd0, 1'b0, FUNCT_NONE, 1'b0);

    // Reset state and first fetch timing with ADDI x1,x0,5.
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(outs), 32'd0);
    rst_n = 1'b1;
    #1 check("idle_no_request", 32'(ir_addr_valid), 32'd0);
    @(negedge clk);
    check("fetch_cycle1", 32'(ir_addr_valid), 32'd1);
    issue(INST_TYPE_INT_IMM, FUNCT_ADD, 1'b0, 1'b1,
          mk(1'b1, RD_DIN_SEL_ALU, PC_SEL_PC_PLUS_4, ALU_SRC_IMM, FUNCT_ADD, 1'b0));
    @(negedge clk);
    @(negedge clk);
    check("addi_exec_cycle4", 32'({pc_en, rd_en, alu_src_sel}), 32'd7);
    @(negedge clk);
    check("next_fetch_cycle5", 32'(ir_addr_valid), 32'd1);

    // JAL, LUI, BEQ (not taken / taken), ADD reg-reg.
    issue(INST_TYPE_JAL, FUNCT_NONE, 1'b0, 1'b1,
          mk(1'b1, RD_DIN_SEL_PC_PLUS_4, PC_SEL_PC_PLUS_IMM, ALU_SRC_RS2, FUNCT_NONE, 1'b0));
    issue(INST_TYPE_IMM, FUNCT_NONE, 1'b0, 1'b1,
          mk(1'b1, RD_DIN_SEL_IMM, PC_SEL_PC_PLUS_4, ALU_SRC_RS2, FUNCT_NONE, 1'b0));
    issue(INST_TYPE_BRANCH, FUNCT_EQ, 1'b0, 1'b1,
          mk(1'b0, 2'd0, PC_SEL_PC_PLUS_4, ALU_SRC_RS2, FUNCT_EQ, 1'b0));
    issue(INST_TYPE_BRANCH, FUNCT_EQ, 1'b1, 1'b1,
          mk(1'b0, 2'd0, PC_SEL_PC_PLUS_IMM, ALU_SRC_RS2, FUNCT_EQ, 1'b0));
    issue(INST_TYPE_INT_REG, FUNCT_ADD, 1'b0, 1'b1,
          mk(1'b1, RD_DIN_SEL_ALU, PC_SEL_PC_PLUS_4, ALU_SRC_RS2, FUNCT_ADD, 1'b0));

    // SW with dw_ready 3 cycles late and the response 2 cycles into the wait.
    dw_delay = 3;
    resp_delay = 2;
    issue(INST_TYPE_STORE, FUNCT_MEM_WORD, 1'b0, 1'b1,
          mk(1'b0, 2'd0, PC_SEL_PC_PLUS_4, 1'b0, FUNCT_NONE, 1'b1));
    dv = 0; pcc = 0; pcbad = 0; rdc = 0; stbad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dw_valid) begin
        dv++;
        if (alu_src_sel != ALU_SRC_IMM || alu_op != FUNCT_MEM_WORD) stbad++;
      end
      if (pc_en) pcc++;
      if (pc_en && !dw_resp_valid) pcbad++;
      if (rd_en) rdc++;
      if (dw_resp_ready && dw_resp_valid) break;
    end
    check("sw_dw_valid_cycles", 32'(dv), 32'd4);
    check("sw_alu_during_store", 32'(stbad), 32'd0);
    check("sw_pc_en_count", 32'(pcc), 32'd1);
    check("sw_pc_en_outside_resp", 32'(pcbad), 32'd0);
    check("sw_rd_en_count", 32'(rdc), 32'd0);

    // Reset while waiting for the store response.
    resp_delay = 50;
    issue(INST_TYPE_STORE, FUNCT_MEM_WORD, 1'b0, 1'b0, none);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dw_resp_ready) begin
        cnt = 1;
        break;
      end
    end
    check("store_wait_reached", 32'(cnt), 32'd1);
    rst_n = 1'b0;
    #1 check("reset_in_store_wait", 32'(outs), 32'd0);
    repeat (2) @(negedge clk);
    resp_delay = 2;
    rst_n = 1'b1;
    #1 check("restart_idle", 32'(ir_addr_valid), 32'd0);
    @(negedge clk);
    check("restart_fetch", 32'(ir_addr_valid), 32'd1);
    check("restart_flags", 32'({illegal_inst, bus_error}), 32'd0);

    // All-zero word: illegal type.
    issue(INST_TYPE_NONE, FUNCT_NONE, 1'b0, 1'b0, none);
    @(negedge clk);
    check("illegal_zero_in_decode", 32'(illegal_inst), 32'd0);
    @(negedge clk);
    check("illegal_zero_flag", 32'(illegal_inst), 32'd1);
    check_halted("illegal_zero_halt");
    rst_n = 1'b0;
    @(negedge clk);
    check("illegal_cleared_by_reset", 32'(illegal_inst), 32'd0);
    rst_n = 1'b1;

    // SLLI decoded with funct 0: illegal.
    issue(INST_TYPE_INT_IMM, FUNCT_NONE, 1'b0, 1'b0, none);
    @(negedge clk);
    @(negedge clk);
    check("illegal_slli_flag", 32'(illegal_inst), 32'd1);
    check_halted("illegal_slli_halt");
    rst_n = 1'b0;
    @(negedge clk);

    // Address never accepted: bus_error after 15 waiting cycles.
    addr_stall = 1'b1;
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ir_addr_valid) cnt++;
      else break;
    end
    check("timeout_request_cycles", 32'(cnt), 32'd15);
    @(negedge clk);
    check("timeout_bus_error", 32'({bus_error, illegal_inst}), 32'd2);
    check_halted("timeout_halt");
    check("timeout_flag_sticky", 32'(bus_error), 32'd1);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
